// File: rtl/stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_pkg                                                   |
// | Description : Shared constants, entry type and pointer-width helper for    |
// |               the valid/ready/last byte stream blocks.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stream_pkg;

    localparam int c_LEN   = 8;
    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic             last;
        logic [c_LEN-1:0] data;
    } entry_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_fifo_mem                                              |
// | Description : DEPTH x (LEN+1) register array, one write port and one       |
// |               asynchronous read port. Contents are intentionally unreset.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_fifo_mem #(
    parameter int LEN   = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [LEN:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [LEN:0]  rdata
);

    logic [LEN:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_fifo                                                  |
// | Description : Show-ahead elastic buffer for the valid/ready/last stream.   |
// |               Optional occupancy port enabled by STREAM_FIFO_LEVEL_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_fifo
    import stream_pkg::*;
#(
    parameter int LEN   = c_LEN,
    parameter int DEPTH = c_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] data_in,
    input  logic           valid_in,
    input  logic           last_in,
    output logic           ready_out,
    output logic [LEN-1:0] data,
    output logic           valid,
    output logic           last,
    input  logic           ready
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] level
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = ptr_w(DEPTH);

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            r_out_en;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [LEN:0]    w_wr_entry;
    logic [LEN:0]    w_rd_entry;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Holds ready_out low during reset and releases it one edge later.
    assign ready_out = r_out_en && !w_full;
    assign valid     = !w_empty;

    assign w_push     = valid_in && ready_out;
    assign w_pop      = valid && ready;
    assign w_wr_entry = {last_in, data_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_en <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_out_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    stream_fifo_mem #(
        .LEN   (LEN),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[c_AW-1:0]),
        .wdata (w_wr_entry),
        .raddr (r_rd_ptr[c_AW-1:0]),
        .rdata (w_rd_entry)
    );

    // Gate the unreset array so stale entries never reach the sink.
    assign {last, data} = valid ? w_rd_entry : '0;

`ifdef STREAM_FIFO_LEVEL_EN
    assign level = r_wr_ptr - r_rd_ptr;
`endif

endmodule
`default_nettype wire

// File: doc/stream_fifo.md
# stream_fifo

Elastic buffer for the valid/ready/last byte stream, placed directly downstream of the `sumr` adder and upstream of `sinkr`. It absorbs back-pressure from the sink so the adder and both sources keep streaming while the sink stalls. Packet boundaries (`last`) travel with each word. Words leave in strict arrival order.

## Interface
Parameters:
- `LEN`, 8, data word width in bits
- `DEPTH`, 4, number of entries; power of two, ≥ 2

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-low
- `data_in`  in  LEN  word from the adder
- `valid_in`  in  1  `data_in` and `last_in` are valid
- `last_in`  in  1  final word of the current packet
- `ready_out`  out  1  FIFO accepts a word this cycle
- `data`  out  LEN  head-of-queue word to the sink
- `valid`  out  1  `data` and `last` are valid
- `last`  out  1  head word ends its packet
- `ready`  in  1  sink accepts the head word this cycle
- `level`  out  clog2(DEPTH)+1  occupancy; present only with `STREAM_FIFO_LEVEL_EN`

## Operation
- Storage: `DEPTH` entries, each `{last, data}` (LEN+1 bits).
- Pointers: `wr_ptr` and `rd_ptr`, each AW+1 bits, where AW = clog2(DEPTH). The MSB is the wrap bit.
  - empty when `wr_ptr == rd_ptr`
  - full when the MSBs differ and the lower AW bits are equal
- Push: `valid_in && ready_out`. Write `{last_in, data_in}` to `mem[wr_ptr[AW-1:0]]`, then increment `wr_ptr`.
- Pop: `valid && ready`. Increment `rd_ptr`.
- Push and pop in the same cycle are both performed. Occupancy is unchanged.
- `ready_out = !full`. It is combinational from registered state only and never depends on `ready`, so there is no combinational path from input to output.
- `valid = !empty`.
- `{last, data} = valid ? mem[rd_ptr[AW-1:0]] : 0`. This is show-ahead: the head word is visible without a pop.
- Pointer arithmetic wraps modulo 2·DEPTH. There is no saturation and no error path, because the handshake makes overflow and underflow impossible.
- `last` has no internal meaning. The FIFO does not count or reframe packets.

## Timing
- Reset (`rst` low, asynchronous): both pointers become 0. Resulting outputs:
  - `valid` = 0, `data` = 0, `last` = 0
  - `level` = 0
  - `ready_out` is forced to 0 while `rst` is low and goes to 1 on the first cycle after release.
- Memory contents are not reset. They are never observable because of the output gating.
- Latency: a word pushed at edge N is presented with `valid` = 1 after edge N. Minimum pass-through is 1 cycle.
- Throughput: one word per cycle in and out whenever 0 < occupancy < DEPTH.
- Full state: `ready_out` = 0. A pop at edge N raises `ready_out` after edge N, and the next push can occur at edge N+1.
- Empty state: `valid` = 0, and `ready` is ignored. A simultaneous push in the empty state leaves `valid` = 1 after the edge.
- `valid` is held, and `data`/`last` are held stable, until the pop completes. This satisfies the AXI-stream-style rule.
- Reset asserted mid-packet: the contents are discarded immediately. Partial packets are not preserved.

## Configuration
- `STREAM_FIFO_LEVEL_EN` defined:
  - Adds the `level` port.
  - `level = wr_ptr - rd_ptr`, registered-state derived, range 0..DEPTH.
- Undefined: no `level` port and no subtractor. All other behaviour is identical.

## Structure
- Shared package `stream_pkg` holds:
  - the default `LEN` (8)
  - `DEPTH` (4)
  - a typedef for the `{last, data}` entry
  - the `ptr_w(DEPTH)` helper returning clog2(DEPTH)+1
- One sub-module, `stream_fifo_mem`: a DEPTH×(LEN+1) register array with one write port and one asynchronous read port. The pointer and flag logic stays in `stream_fifo`.

## Test plan
1. Reset release, `valid_in` = 0: `valid` = 0, `data` = 0, `ready_out` 0→1 on the first cycle after release, `level` = 0.
2. Single word 0x5A with `last_in` = 1 and `ready` = 1: `valid` = 1, `data` = 0x5A, `last` = 1 one cycle later, then `valid` = 0.
3. `ready` = 0, push 0x01..0x04: after the 4th push `ready_out` = 0 and `level` = 4, and a 5th offered word 0x05 is not accepted. Then `ready` = 1: out 0x01, 0x02, 0x03, 0x04, 0x05 in order, one per cycle.
4. Continuous streaming of 20 words with `ready` = 1: no bubbles, output equals input delayed by 1 cycle, and the pointers wrap cleanly.
5. Random `valid_in`/`ready` toggling over 200 words, with `last` every 8th word: scoreboard matches data and `last` exactly, and `valid`/`data` never change while `valid && !ready`.
6. `rst` pulsed low with 3 words buffered: `valid` = 0 immediately (asynchronous), and the next word pushed after release is the first word seen at the output.
